// File: rtl/uart_rx_fifo_mapper.sv
// UART receive FIFO exposed to the 6502 bus as a data register, a status register and a level interrupt.
// Optional idle-timeout flag is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo_mapper #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int IRQ_LEVEL      = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] uart_byte,
  input  logic              uart_byte_ready,
  input  logic              reg_sel,
  input  logic              rd_strobe,
  input  logic              clear_interupt,
  output logic [DATA_W-1:0] data_bus,
  output logic              interupt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DATA_W < 8) begin : g_bad_data_w
    $error("uart_rx_fifo_mapper: DATA_W must be >= 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo_mapper: DEPTH must be a power of 2 and >= 2");
  end
  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("uart_rx_fifo_mapper: IRQ_LEVEL must be in 1..DEPTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_rx_fifo_mapper: TIMEOUT_CYCLES must be >= 1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overrun_q, overrun_d;

  logic empty, full, watermark;
  logic do_push, do_pop, overrun_set;
  logic timeout_flag;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign watermark = (count_q >= CNT_W'(IRQ_LEVEL));

  // A push into a full FIFO is still accepted when the same cycle pops a slot free.
  assign do_pop      = rd_strobe & ~reg_sel & ~empty;
  assign do_push     = uart_byte_ready & (~full | do_pop);
  assign overrun_set = uart_byte_ready & full & ~do_pop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (overrun_set)         overrun_d = 1'b1;
    else if (clear_interupt) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= uart_byte;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int               IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
  logic              idle_rst, timeout_set;

  assign idle_rst = do_push | do_pop | empty;
  // Fire only on the step into saturation so a CPU clear is not immediately undone.
  assign timeout_set = ~idle_rst & (idle_q == IDLE_MAX - IDLE_W'(1));

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (idle_rst)              idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
    if (timeout_set)         timeout_d = 1'b1;
    else if (clear_interupt) timeout_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  logic [DATA_W-1:0] status_word;
  assign status_word = {{(DATA_W-5){1'b0}}, timeout_flag, overrun_q, watermark, full, ~empty};

  assign data_bus = reg_sel ? status_word : (empty ? '0 : mem_q[rd_ptr_q]);
  assign interupt = watermark | overrun_q | timeout_flag;

endmodule

// File: tb/tb_uart_rx_fifo_mapper.sv
// Scoreboard bench for uart_rx_fifo_mapper: three instances (IRQ_LEVEL 1, 4, 8) driven by directed vectors.
// Expected reads are queued at issue time; a negedge monitor pops and compares whenever a read strobe is high.
module tb_uart_rx_fifo_mapper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ub  [3];
  logic       ubr [3];
  logic       sel [3];
  logic       rd  [3];
  logic       clr [3];
  logic [7:0] db  [3];
  logic       irq [3];

  always #5 clk = ~clk;

  uart_rx_fifo_mapper #(.DATA_W(8), .DEPTH(16), .IRQ_LEVEL(1), .TIMEOUT_CYCLES(10)) u_lvl1 (
    .clk(clk), .rst_n(rst_n), .uart_byte(ub[0]), .uart_byte_ready(ubr[0]), .reg_sel(sel[0]),
    .rd_strobe(rd[0]), .clear_interupt(clr[0]), .data_bus(db[0]), .interupt(irq[0]));

  uart_rx_fifo_mapper #(.DATA_W(8), .DEPTH(16), .IRQ_LEVEL(4), .TIMEOUT_CYCLES(1000)) u_lvl4 (
    .clk(clk), .rst_n(rst_n), .uart_byte(ub[1]), .uart_byte_ready(ubr[1]), .reg_sel(sel[1]),
    .rd_strobe(rd[1]), .clear_interupt(clr[1]), .data_bus(db[1]), .interupt(irq[1]));

  uart_rx_fifo_mapper #(.DATA_W(8), .DEPTH(16), .IRQ_LEVEL(8), .TIMEOUT_CYCLES(10)) u_lvl8 (
    .clk(clk), .rst_n(rst_n), .uart_byte(ub[2]), .uart_byte_ready(ubr[2]), .reg_sel(sel[2]),
    .rd_strobe(rd[2]), .clear_interupt(clr[2]), .data_bus(db[2]), .interupt(irq[2]));

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [7:0] TO_BIT = 8'h10;
  localparam logic       TO_IRQ = 1'b1;
`else
  localparam logic [7:0] TO_BIT = 8'h00;
  localparam logic       TO_IRQ = 1'b0;
`endif

  typedef struct {
    int         dut;
    logic [7:0] d;
    logic       irq;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got data=%h irq=%b, expected data=%h irq=%b",
               nm, act[7:0], act[8], exp[7:0], exp[8]);
    end
  endtask

  // Monitor: one comparison per read strobe seen on any instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd[i] === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_read dut%0d: got data=%h irq=%b, expected no read", i, db[i], irq[i]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.dut != i) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: read seen on dut%0d, expected dut%0d", e.name, i, e.dut);
          end else begin
            check(e.name, {irq[i], db[i]}, {e.irq, e.d});
          end
        end
      end
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    ub[i] = b; ubr[i] = 1'b1;
    @(posedge clk); #1;
    ubr[i] = 1'b0;
  endtask

  task automatic rd_exp(input int i, input logic s, input logic [7:0] d, input logic ir, input string nm);
    sel[i] = s; rd[i] = 1'b1;
    sb.push_back('{dut: i, d: d, irq: ir, name: nm});
    @(posedge clk); #1;
    rd[i] = 1'b0; sel[i] = 1'b0;
  endtask

  task automatic push_pop(input int i, input logic [7:0] b, input logic [7:0] d, input logic ir, input string nm);
    ub[i] = b; ubr[i] = 1'b1; sel[i] = 1'b0; rd[i] = 1'b1;
    sb.push_back('{dut: i, d: d, irq: ir, name: nm});
    @(posedge clk); #1;
    ubr[i] = 1'b0; rd[i] = 1'b0;
  endtask

  task automatic clear(input int i);
    clr[i] = 1'b1;
    @(posedge clk); #1;
    clr[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ub[i] = 8'h00; ubr[i] = 1'b0; sel[i] = 1'b0; rd[i] = 1'b0; clr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state on every instance
    rd_exp(0, 1'b1, 8'h00, 1'b0, "reset_status_l1");
    rd_exp(1, 1'b1, 8'h00, 1'b0, "reset_status_l4");
    rd_exp(2, 1'b0, 8'h00, 1'b0, "reset_data_l8");

    // Single byte, watermark 1
    push(0, 8'h41);
    rd_exp(0, 1'b1, 8'h05, 1'b1, "t1_status");
    rd_exp(0, 1'b0, 8'h41, 1'b1, "t1_data");
    rd_exp(0, 1'b1, 8'h00, 1'b0, "t1_status_empty");

    // Watermark 4
    for (int k = 1; k <= 3; k++) push(1, 8'(k));
    rd_exp(1, 1'b1, 8'h01, 1'b0, "t2_status_below");
    push(1, 8'h04);
    rd_exp(1, 1'b1, 8'h05, 1'b1, "t2_status_at");
    rd_exp(1, 1'b0, 8'h01, 1'b1, "t2_data1");
    rd_exp(1, 1'b0, 8'h02, 1'b0, "t2_data2");
    rd_exp(1, 1'b0, 8'h03, 1'b0, "t2_data3");
    rd_exp(1, 1'b0, 8'h04, 1'b0, "t2_data4");
    rd_exp(1, 1'b1, 8'h00, 1'b0, "t2_status_empty");

    // Overrun on the 17th byte
    for (int k = 0; k < 17; k++) push(0, 8'(8'h10 + k));
    rd_exp(0, 1'b1, 8'h0F, 1'b1, "t3_status_overrun");
    clear(0);
    rd_exp(0, 1'b1, 8'h07, 1'b1, "t3_status_cleared");
    for (int k = 0; k < 16; k++) rd_exp(0, 1'b0, 8'(8'h10 + k), 1'b1, $sformatf("t3_drain%0d", k));
    rd_exp(0, 1'b1, 8'h00, 1'b0, "t3_status_empty");

    // Full FIFO with same-cycle push and pop, then empty push and pop
    for (int k = 0; k < 16; k++) push(0, 8'(8'h60 + k));
    push_pop(0, 8'h55, 8'h60, 1'b1, "t4_full_pushpop_head");
    rd_exp(0, 1'b1, 8'h07, 1'b1, "t4_status_full_no_ovr");
    for (int k = 1; k < 16; k++) rd_exp(0, 1'b0, 8'(8'h60 + k), 1'b1, $sformatf("t4_drain%0d", k));
    rd_exp(0, 1'b0, 8'h55, 1'b1, "t4_drain_last_55");
    rd_exp(0, 1'b1, 8'h00, 1'b0, "t4_status_empty");
    push_pop(0, 8'h77, 8'h00, 1'b0, "t4_empty_pushpop_head");
    rd_exp(0, 1'b1, 8'h05, 1'b1, "t4_status_count1");
    rd_exp(0, 1'b0, 8'h77, 1'b1, "t4_data_77");

    // Idle timeout on the IRQ_LEVEL=8 instance
    push(2, 8'h99);
    idle(8);
    rd_exp(2, 1'b1, 8'h01, 1'b0, "t6_status_idle9");
    push(2, 8'h9A);
    idle(9);
    rd_exp(2, 1'b1, 8'h01, 1'b0, "t6_status_restarted");
    rd_exp(2, 1'b1, 8'h01 | TO_BIT, TO_IRQ, "t6_status_timeout");
    clear(2);
    rd_exp(2, 1'b1, 8'h01, 1'b0, "t6_status_cleared");
    rd_exp(2, 1'b0, 8'h99, 1'b0, "t6_data_99");
    rd_exp(2, 1'b0, 8'h9A, 1'b0, "t6_data_9a");
    rd_exp(2, 1'b1, 8'h00, 1'b0, "t6_status_empty");

    // Reset with data queued
    push(0, 8'h31);
    push(0, 8'h32);
    push(0, 8'h33);
    rst_n = 1'b0;
    rd_exp(0, 1'b0, 8'h00, 1'b0, "t5_rst_data");
    rd_exp(0, 1'b1, 8'h00, 1'b0, "t5_rst_status");
    rst_n = 1'b1;
    push(0, 8'h7E);
    rd_exp(0, 1'b0, 8'h7E, 1'b1, "t5_data_7e");
    rd_exp(0, 1'b1, 8'h00, 1'b0, "t5_status_empty");

    idle(2);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected reads never seen, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
